// File: rtl/delay_sched.sv
// delay_sched: shares one saturating delay counter among NREQ
// requesters with round-robin arbitration and grant/done pulses.
module delay_sched #(
  parameter int NREQ  = 4,
  parameter int CBITS = 15,
  parameter int N     = 17500
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*CBITS-1:0]    len,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     err
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [CBITS-1:0] r_cnt;
  logic [CBITS-1:0] r_tgt;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_owner;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic             r_err;

  logic             w_any;
  logic [IW-1:0]    w_sel;
  logic [IW-1:0]    w_nptr;
  logic [CBITS-1:0] w_len;
  logic [CBITS-1:0] w_tgt;
  logic             w_over;
  logic             w_fin;
  logic [NREQ-1:0]  w_one;

  // Pick the first pending request at or after the rotating pointer.
  always_comb begin
    int v_idx;
    w_any = 1'b0;
    w_sel = '0;
    v_idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      v_idx = int'(r_ptr) + i;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!w_any && req[v_idx]) begin
        w_any = 1'b1;
        w_sel = IW'(v_idx);
      end
    end
  end

  assign w_len  = len[w_sel*CBITS +: CBITS];
  assign w_over = w_len > CBITS'(N);
  assign w_tgt  = w_over ? CBITS'(N) : w_len;
  assign w_nptr = (w_sel == IW'(NREQ-1)) ? '0 : w_sel + 1'b1;
  assign w_fin  = r_cnt >= r_tgt;
  assign w_one  = {{(NREQ-1){1'b0}}, 1'b1};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  // Next-state decode: grant, count out, one done cycle.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_nxt = S_RUN;
      S_RUN:   if (w_fin) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch grant parameters, count, and emit pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_sel;
            r_tgt   <= w_tgt;
            r_cnt   <= '0;
            r_gnt   <= w_one << w_sel;
            r_ptr   <= w_nptr;
            if (w_over) r_err <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_fin) r_done <= w_one << r_owner;
          else       r_cnt  <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign busy  = (r_state != S_IDLE);
  assign owner = r_owner;
  assign err   = r_err;

endmodule

// File: tb/tb_delay_sched.sv
// tb_delay_sched: scoreboard bench for delay_sched; expected grant/done
// events with cycle gaps are queued by the driver and matched on output.
module tb_delay_sched;

  localparam int NREQ  = 4;
  localparam int CBITS = 15;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*CBITS-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [1:0]            owner;
  logic                  err;

  typedef struct {
    bit dn;
    int idx;
    int gap;
  } ev_t;

  ev_t sb[$];
  int  n_run;
  int  n_fail;
  int  cyc;
  int  mark_cyc;
  int  last_cyc;

  delay_sched #(.NREQ(NREQ), .CBITS(CBITS), .N(17500)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .owner (owner),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int obs, int exp);
    n_run++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(bit dn, int idx, int gap);
    ev_t e;
    e.dn  = dn;
    e.idx = idx;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic got_ev(bit dn, logic [NREQ-1:0] v);
    ev_t e;
    int  base;
    if (sb.size() == 0) begin
      chk(dn ? "extra_done" : "extra_gnt", int'(v), 0);
    end else begin
      e    = sb.pop_front();
      base = (last_cyc > mark_cyc) ? last_cyc : mark_cyc;
      chk("kind", int'(dn), int'(e.dn));
      chk(dn ? "done_vec" : "gnt_vec", int'(v), 1 << e.idx);
      chk(dn ? "done_gap" : "gnt_gap", cyc - base, e.gap);
      if (!dn) chk("owner", int'(owner), e.idx);
    end
    last_cyc = cyc;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        if (|gnt)  got_ev(1'b0, gnt);
        if (|done) got_ev(1'b1, done);
      end
    end
  endtask

  task automatic go(logic [NREQ-1:0] r);
    req      = r;
    mark_cyc = cyc;
  endtask

  task automatic wait_gnt(int idx, int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (gnt[idx]) return;
    end
    chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_idle(int budget, output int bc);
    bc = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (sb.size() == 0 && !busy) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_len(int i, int v);
    len[i*CBITS +: CBITS] = CBITS'(v);
  endtask

  initial begin
    int bc;
    int b0;
    n_run    = 0;
    n_fail   = 0;
    mark_cyc = 0;
    last_cyc = 0;
    rst      = 1'b0;
    req      = '0;
    len      = '0;
    fork
      monitor();
    join_none

    // reset values
    do_reset();
    @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_err", int'(err), 0);

    // single requester, len 5
    set_len(0, 5);
    push(0, 0, 1);
    push(1, 0, 6);
    go(4'b0001);
    wait_gnt(0, 20);
    b0  = int'(busy);
    req = '0;
    wait_idle(50, bc);
    chk("busy_len", b0 + bc, 7);

    // round robin, all held, len 2
    do_reset();
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    push(0, 0, 1);
    push(1, 0, 3);
    for (int i = 1; i < 5; i++) begin
      push(0, i % NREQ, 2);
      push(1, i % NREQ, 3);
    end
    go(4'b1111);
    for (int g = 0; g < 5; g++) wait_gnt(g % NREQ, 20);
    req = '0;
    wait_idle(50, bc);

    // clamp and sticky error
    do_reset();
    set_len(1, 20000);
    push(0, 1, 1);
    push(1, 1, 17501);
    go(4'b0010);
    wait_gnt(1, 20);
    chk("err_set", int'(err), 1);
    req = '0;
    wait_idle(20000, bc);
    chk("err_sticky", int'(err), 1);
    do_reset();
    @(negedge clk);
    chk("err_clr", int'(err), 0);

    // zero length and withdrawal
    set_len(2, 0);
    set_len(3, 4);
    push(0, 2, 1);
    push(1, 2, 1);
    go(4'b1100);
    wait_gnt(2, 20);
    req = '0;
    wait_idle(50, bc);
    repeat (10) @(negedge clk);
    chk("wd_busy", int'(busy), 0);

    // async reset mid-run, then fresh pointer
    do_reset();
    set_len(2, 10);
    push(0, 2, 1);
    go(4'b0100);
    wait_gnt(2, 20);
    req = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_gnt", int'(gnt), 0);
    chk("ar_done", int'(done), 0);
    chk("ar_owner", int'(owner), 0);
    @(negedge clk);
    rst = 1'b1;
    set_len(1, 1);
    push(0, 1, 1);
    push(1, 1, 2);
    go(4'b1010);
    wait_gnt(1, 20);
    req = '0;
    wait_idle(50, bc);
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
